// File: rtl/instr_fetch_issue_if.sv
// Bus bundle between the fetch/issue sequencer, instruction memory and the decode/datapath side.
// The sequencer uses the master modport. The memory/decoder environment uses the slave modport.
interface instr_fetch_issue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  OP;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic        Branch;
  logic        JumpSignal;
  logic        zero;
  logic        halted;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, issue_valid, OP, rs, rt, rd, funct, imm16,
           pc_out, halted, retired,
    input  imem_ack, imem_rdata, issue_ready, Branch, JumpSignal, zero
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, OP, rs, rt, rd, funct, imm16,
           pc_out, halted, retired,
    output imem_ack, imem_rdata, issue_ready, Branch, JumpSignal, zero
  );
endinterface

// File: rtl/instr_fetch_issue.sv
// Fetch/issue sequencer: fetches MIPS words over req/ack and holds each one on the issue port.
// The next PC is chosen from the jump, branch and zero inputs sampled at the issue handshake.
module instr_fetch_issue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input logic               clk,
  input logic               clr,
  instr_fetch_issue_if.master bus
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    ISSUE    = 2'd2,
    HALT     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;

  logic        handshake;
  logic [31:0] pc4;
  logic [31:0] br_off;

  assign handshake = (state_q == ISSUE) && bus.issue_ready;
  assign pc4       = pc_q + 32'd4;
  assign br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= RST_WAIT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = (bus.imem_rdata[31:26] == HALT_OP) ? HALT : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          // Jump outranks branch when the decoder raises both.
          if (bus.JumpSignal)
            pc_d = {pc4[31:28], instr_q[25:0], 2'b00};
          else if (bus.Branch && bus.zero)
            pc_d = pc4 + br_off;
          else
            pc_d = pc4;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RST_WAIT;
    endcase
  end

  // Request and status are decoded from the state flop, so the async reset drops them at once.
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.issue_valid = (state_q == ISSUE);
  assign bus.halted      = (state_q == HALT);
  assign bus.retired     = retired_q;
  assign bus.pc_out      = pc_q;
  assign bus.OP          = instr_q[31:26];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.funct       = instr_q[5:0];
  assign bus.imm16       = instr_q[15:0];

endmodule
